// File: rtl/siso_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : siso_frame_ctrl
// Brief    : Parallel-in serial-out framer: start bit, WIDTH data bits LSB
//            first, optional even-parity bit (macro SISO_PARITY_EN), stop bit.
// Revision : 1.0  initial release
// ============================================================================
module siso_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             busy,
  output logic             done
);

  localparam int c_timer_w = $clog2(DIV + 1);
  localparam int c_count_w = $clog2(WIDTH + 1);
  localparam logic [c_timer_w-1:0] c_tick_last = c_timer_w'(DIV - 1);
  localparam logic [c_count_w-1:0] c_bit_last  = c_count_w'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SISO_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_timer_w-1:0] r_timer;
  logic [c_count_w-1:0] r_count;
  logic [WIDTH-1:0]     r_shift;
`ifdef SISO_PARITY_EN
  logic                 r_parity;
`endif

  logic             w_tick_last;
  logic [WIDTH-1:0] w_shift_next;

  assign w_tick_last  = (r_timer == c_tick_last);
  assign w_shift_next = r_shift >> 1;

  // data_out is loaded with the level of the state being entered, so the
  // line changes on the same edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_count  <= '0;
      r_shift  <= '0;
`ifdef SISO_PARITY_EN
      r_parity <= 1'b0;
`endif
      data_out <= 1'b1;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          data_out <= 1'b1;
          if (in_valid && in_ready) begin
            r_shift  <= par_in;
`ifdef SISO_PARITY_EN
            r_parity <= ^par_in;
`endif
            r_timer  <= '0;
            r_count  <= '0;
            r_state  <= S_START;
            data_out <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end

        S_START: begin
          if (w_tick_last) begin
            r_timer  <= '0;
            r_state  <= S_DATA;
            data_out <= r_shift[0];
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_DATA: begin
          if (w_tick_last) begin
            r_timer <= '0;
            r_shift <= w_shift_next;
            r_count <= r_count + 1'b1;
            if (r_count == c_bit_last) begin
`ifdef SISO_PARITY_EN
              r_state  <= S_PARITY;
              data_out <= r_parity;
`else
              r_state  <= S_STOP;
              data_out <= 1'b1;
`endif
            end else begin
              data_out <= w_shift_next[0];
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

`ifdef SISO_PARITY_EN
        S_PARITY: begin
          if (w_tick_last) begin
            r_timer  <= '0;
            r_state  <= S_STOP;
            data_out <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif

        S_STOP: begin
          data_out <= 1'b1;
          if (w_tick_last) begin
            r_timer  <= '0;
            r_state  <= S_IDLE;
            done     <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_timer  <= '0;
          r_count  <= '0;
          data_out <= 1'b1;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_siso_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_siso_frame_ctrl
// Brief    : Self-checking bench for siso_frame_ctrl (WIDTH=8/DIV=4 and
//            WIDTH=1/DIV=1 instances), frame model computed from slot index.
// Revision : 1.0  initial release
// ============================================================================
module tb_siso_frame_ctrl;

  localparam int W = 8;
  localparam int D = 4;
`ifdef SISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] par_in;
  logic         in_valid;
  logic         in_ready, data_out, busy, done;

  logic [0:0]   p1;
  logic         v1;
  logic         rdy1, dout1, busy1, done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  siso_frame_ctrl #(.WIDTH(W), .DIV(D)) u_dut (
    .clk(clk), .rst(rst), .par_in(par_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .busy(busy), .done(done)
  );

  siso_frame_ctrl #(.WIDTH(1), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .par_in(p1), .in_valid(v1),
    .in_ready(rdy1), .data_out(dout1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [7:0] word;
    logic       par;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int frame_len(input int width, input int div);
    return (width + 2 + PAR) * div;
  endfunction

  function automatic logic ref_parity(input logic [31:0] w, input int width);
    logic p = 1'b0;
    for (int i = 0; i < width; i++) p ^= w[i];
    return p;
  endfunction

  // Line level at cycle c after accept: slot 0 start, 1..width data, then
  // optional parity, then stop/idle (1).
  function automatic logic model_level(input logic [31:0] w, input logic par,
                                       input int width, input int div, input int c);
    int slot = c / div;
    if (slot == 0) return 1'b0;
    if (slot <= width) return w[slot-1];
    if (PAR == 1 && slot == width + 1) return par;
    return 1'b1;
  endfunction

  task automatic start_accept(input logic [W-1:0] word);
    @(negedge clk);
    check("ready_before_accept", in_ready, 1);
    par_in   = word;
    in_valid = 1'b1;
  endtask

  task automatic watch_frame(input logic [W-1:0] word, input logic par, input bit keep,
                             input logic [W-1:0] next, input bit noise);
    int total = frame_len(W, D);
    int last  = keep ? total : total + 1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (keep) begin
        in_valid = 1'b1;
        par_in   = next;
      end else begin
        par_in   = W'($urandom);
        in_valid = (noise && c < total) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (c <= total) begin
        check($sformatf("data_out w=%0h c=%0d", word, c), data_out, model_level(word, par, W, D, c));
        check($sformatf("busy w=%0h c=%0d", word, c), busy, (c < total));
        check($sformatf("done w=%0h c=%0d", word, c), done, (c == total));
        check($sformatf("in_ready w=%0h c=%0d", word, c), in_ready, (c == total));
      end else begin
        check($sformatf("post_done w=%0h", word), done, 0);
        check($sformatf("post_busy w=%0h", word), busy, 0);
        check($sformatf("post_line w=%0h", word), data_out, 1);
      end
    end
  endtask

  task automatic frame1(input logic [0:0] word);
    int total = frame_len(1, 1);
    @(negedge clk);
    check("w1_ready_before", rdy1, 1);
    p1 = word;
    v1 = 1'b1;
    for (int c = 0; c <= total; c++) begin
      @(negedge clk);
      v1 = 1'b0;
      p1 = 1'($urandom);
      check($sformatf("w1 data_out w=%0d c=%0d", word, c), dout1, model_level(32'(word), word[0], 1, 1, c));
      check($sformatf("w1 done w=%0d c=%0d", word, c), done1, (c == total));
      check($sformatf("w1 busy w=%0d c=%0d", word, c), busy1, (c < total));
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h0F, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'h7F, 1'b1};
    vecs[7] = '{8'h3C, 1'b0};

    par_in   = '0;
    in_valid = 1'b0;
    p1       = '0;
    v1       = 1'b0;

    // Asynchronous reset, checked before the first clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_data_out", data_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_w1_data_out", dout1, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reference frame A5, then the vector table with input noise while busy.
    start_accept(8'hA5);
    watch_frame(8'hA5, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      start_accept(vecs[i].word);
      watch_frame(vecs[i].word, vecs[i].par, 1'b0, '0, 1'b1);
    end

    // Back-to-back: FF is held valid and taken on the done cycle.
    start_accept(8'h0F);
    watch_frame(8'h0F, 1'b0, 1'b1, 8'hFF, 1'b0);
    watch_frame(8'hFF, 1'b0, 1'b0, '0, 1'b0);

    // Reset mid-frame at cycle 13.
    start_accept(8'h55);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("abort_pre c=%0d", c), data_out, model_level(32'h55, 1'b0, W, D, c));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_data_out", data_out, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check($sformatf("abort_no_done c=%0d", c), done, 0);
      check($sformatf("abort_idle c=%0d", c), busy, 0);
    end
    // Accept on the very first edge after reset release.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    rst      = 1'b0;
    par_in   = 8'hC3;
    in_valid = 1'b1;
    watch_frame(8'hC3, 1'b0, 1'b0, '0, 1'b0);

    // DIV=1, WIDTH=1 instance.
    frame1(1'b1);
    frame1(1'b0);
    frame1(1'b1);

    // Randomized frames with random idle gaps.
    for (int n = 0; n < 15; n++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_accept(w);
      watch_frame(w, ref_parity(32'(w), W), 1'b0, '0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/siso_frame_ctrl.md
SISO_FRAME_CTRL -- requirements
Module: siso_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per frame (legal range 1 to 32).
REQ-002 SHALL have parameter DIV, default 4, meaning clock cycles per serial bit (legal range 1 to 65535).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port par_in  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port in_valid  input  1  par_in is valid.
REQ-007 SHALL have port in_ready  output  1  controller can accept a word.
REQ-008 SHALL have port data_out  output  1  serial line, registered; idle level 1.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL implement the states IDLE, START, DATA, PARITY (present only per REQ-027) and STOP.
REQ-012 SHALL drive in_ready=1 only in IDLE; busy SHALL equal (state != IDLE).
REQ-013 SHALL accept a word when in_valid and in_ready are both 1 at a rising edge. On that edge: latch par_in into the internal shift register, clear the bit timer and bit counter, enter START and set data_out=0.
REQ-014 SHALL ignore in_valid while busy; par_in changes after acceptance SHALL NOT affect the frame in flight.
REQ-015 SHALL hold each state's line level for exactly DIV cycles, counted by a bit timer that runs 0..DIV-1 and wraps.
REQ-016 In START, data_out SHALL be 0.
REQ-017 In DATA, data_out SHALL be the shift register LSB, so bits go out LSB first.
- At each bit-period end: shift right by one and increment the bit counter.
- After WIDTH bits: go to PARITY if enabled, else STOP.
REQ-018 In STOP, data_out SHALL be 1; at period end the state SHALL return to IDLE.
REQ-019 SHALL assert done for exactly the first IDLE cycle after STOP; in_ready is also 1 in that cycle, so back-to-back accept is legal.
REQ-020 Timing, measured in cycles relative to the accept edge (cycle 0 = first cycle after that edge):
- start bit occupies cycles 0..DIV-1;
- data bit i occupies cycles (1+i)*DIV .. (2+i)*DIV-1;
- stop bit follows the last data bit, or the parity bit when enabled;
- done is asserted at cycle (WIDTH+2)*DIV, plus DIV when parity is enabled.
REQ-021 With DIV=1, each state SHALL last exactly one cycle, with no skipped or repeated bits.
REQ-022 The bit timer SHALL be $clog2(DIV+1) bits wide; the bit counter SHALL be $clog2(WIDTH+1) bits wide. Neither SHALL overflow at legal parameter values.
REQ-023 In IDLE, data_out SHALL be 1 and the shift register SHALL hold its value.

Reset
REQ-024 When rst=1, the block SHALL immediately (asynchronously) force: state=IDLE, data_out=1, done=0, busy=0, timer=0, counter=0, shift register=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; no done pulse SHALL follow.
REQ-026 After rst falls, in_ready SHALL be 1 in the first cycle and an accept SHALL be legal at the first rising edge.

Configuration
REQ-027 Macro SISO_PARITY_EN controls parity.
- When defined: the PARITY state is inserted between DATA and STOP for DIV cycles, and data_out = XOR of the accepted word (even parity).
- When undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

Verification (WIDTH=8, DIV=4 unless stated)
REQ-028 Reset, then accept 8'hA5.
- Required data_out, each level held 4 cycles: 0,1,0,1,0,0,1,0,1,1.
- done=1 at cycle 40; busy=1 for cycles 0..39.
REQ-029 With SISO_PARITY_EN defined, accept 8'hA5 (four ones).
- Parity bit 0 in cycles 36..39.
- Stop bit in cycles 40..43.
- done at cycle 44.
REQ-030 Accept 8'h0F, then hold in_valid=1 with par_in=8'hFF throughout the frame.
- The frame SHALL carry 8'h0F.
- 8'hFF SHALL be accepted exactly at the done cycle (cycle 40), with its start bit beginning at cycle 41.
REQ-031 Accept 8'h55, then assert rst at cycle 13.
- data_out=1 and busy=0 immediately.
- No done pulse.
- A new word accepted after release SHALL frame correctly from its start bit.
REQ-032 With DIV=1, WIDTH=1, accept 1'b1.
- data_out SHALL be 0,1,1 over cycles 0..2.
- done at cycle 3.
